pixel_stream_scan: RTL and testbench

// - Parametrised successor to the top-level VGA pixel streamer. Generates raster-scan (x,y) for the raster

---
 rtl/pixel_stream_scan.sv | 113 +++++++++++
 tb/tb_pixel_stream_scan.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/pixel_stream_scan.sv
// pixel_stream_scan: raster (x,y) issue with credit-limited capture of rgb_in into a valid/ready skid FIFO.
// Build option STREAM_CONTINUOUS_EN: frames stream back-to-back, FSM never leaves RUN after the first frame_req.
module pixel_stream_scan #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int XW         = 10,
  parameter int YW         = 10,
  parameter int PIX_W      = 6,
  parameter int PIPE_LAT   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk_20,
  input  logic             rst_n,
  input  logic             frame_req,
  output logic             coord_valid,
  output logic [XW-1:0]    x,
  output logic [YW-1:0]    y,
  input  logic [PIX_W-1:0] rgb_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_data,
  output logic             out_sof,
  output logic             out_eol,
  output logic             busy,
  output logic             frame_done
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
`ifdef STREAM_CONTINUOUS_EN
  localparam logic [1:0] END_ST = RUN;
`else
  localparam logic [1:0] END_ST = DRAIN;
`endif
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  logic [1:0]          state, state_nx;
  logic [PIPE_LAT-1:0] pv, ps, pe, pf;
  logic [PIX_W+2:0]    mem [FIFO_DEPTH];
  logic [PIX_W+2:0]    head;
  logic [AW-1:0]       rd, wr;
  logic [CW-1:0]       count, inflight;
  logic                x_last, y_last, push, pop;
  assign x_last    = x == XW'(H_ACTIVE - 1);
  assign y_last    = y == YW'(V_ACTIVE - 1);
  assign push      = pv[PIPE_LAT-1];
  assign out_valid = count != '0;
  assign pop       = out_valid && out_ready;
  assign head      = mem[rd];
  assign out_data  = out_valid ? head[PIX_W-1:0] : '0;
  assign out_sof   = out_valid && head[PIX_W];
  assign out_eol   = out_valid && head[PIX_W+1];
  assign busy      = state != IDLE;
  // beats already owed to the FIFO: one per valid stage of the latency pipe
  always_comb begin
    inflight = '0;
    for (int i = 0; i < PIPE_LAT; i++) inflight = inflight + CW'(pv[i]);
  end
  // issue only while every outstanding beat is guaranteed a FIFO slot
  always_comb begin
    coord_valid = (state == RUN) && (({1'b0, count} + {1'b0, inflight}) < (CW+1)'(FIFO_DEPTH));
    state_nx    = state == IDLE ? (frame_req ? RUN : IDLE) :
                  state == RUN  ? (coord_valid && x_last && y_last ? END_ST : RUN) :
                  (pv == '0 && count == '0) ? IDLE : DRAIN;
  end
  // frame sequencing
  always_ff @(posedge clk_20) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  // scan counters advance only on issue
  always_ff @(posedge clk_20) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (coord_valid) begin
      x <= x_last ? '0 : x + XW'(1);
      if (x_last) y <= y_last ? '0 : y + YW'(1);
    end
  end
  // tag pipe tracks each issued coordinate until its rgb_in arrives
  always_ff @(posedge clk_20) begin
    if (!rst_n) begin
      pv <= '0;
      ps <= '0;
      pe <= '0;
      pf <= '0;
    end else begin
      pv <= (pv << 1) | PIPE_LAT'(coord_valid);
      ps <= (ps << 1) | PIPE_LAT'(coord_valid && x == '0 && y == '0);
      pe <= (pe << 1) | PIPE_LAT'(coord_valid && x_last);
      pf <= (pf << 1) | PIPE_LAT'(coord_valid && x_last && y_last);
    end
  end
  // FIFO storage needs no reset; pointers and count define validity
  always_ff @(posedge clk_20) begin
    if (push) mem[wr] <= {pf[PIPE_LAT-1], pe[PIPE_LAT-1], ps[PIPE_LAT-1], rgb_in};
  end
  // FIFO pointers, occupancy and end-of-frame pulse
  always_ff @(posedge clk_20) begin
    if (!rst_n) begin
      rd         <= '0;
      wr         <= '0;
      count      <= '0;
      frame_done <= 1'b0;
    end else begin
      if (push) wr <= wr + AW'(1);
      if (pop) rd <= rd + AW'(1);
      count      <= count + CW'(push) - CW'(pop);
      frame_done <= pop && head[PIX_W+2];
    end
  end
endmodule

// File: tb/tb_pixel_stream_scan.sv
// tb_pixel_stream_scan: scenario table plus corner sequences against a beat-index reference model.
module tb_pixel_stream_scan;
  localparam int H = 4, V = 3, N = H * V, DEPTH = 4;
  logic       clk_20 = 1'b0, rst_n = 1'b0, frame_req = 1'b0, out_ready = 1'b0;
  logic       coord_valid, out_valid, out_sof, out_eol, busy, frame_done;
  logic [9:0] x, y;
  logic [5:0] rgb_in, out_data, d1 = '0, d2 = '0;
  int pass = 0, total = 0;
  int idx = 0, issued = 0, acc = 0, dones = 0, ncyc = 0;
  int t_hs [24];
  logic prev_eof = 1'b0;

  typedef struct { int mode; int hold; int beats; int frames; } vec_t;
  vec_t vt [5];

  pixel_stream_scan #(.H_ACTIVE(H), .V_ACTIVE(V), .XW(10), .YW(10), .PIX_W(6),
                      .PIPE_LAT(2), .FIFO_DEPTH(DEPTH)) dut (
    .clk_20(clk_20), .rst_n(rst_n), .frame_req(frame_req), .coord_valid(coord_valid),
    .x(x), .y(y), .rgb_in(rgb_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sof(out_sof), .out_eol(out_eol), .busy(busy),
    .frame_done(frame_done));

  always #25 clk_20 = ~clk_20;

  // raster colour model: {y,x} of the coordinate shown two cycles earlier
  always @(posedge clk_20) begin
    d1 <= {y[2:0], x[2:0]};
    d2 <= d1;
  end
  assign rgb_in = d2;

  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act == exp) pass++;
    else $display("FAIL %s: got %0d expected %0d", n, act, exp);
  endtask

  // scoreboard: beat k of a frame is pixel (k%H, k/H); outstanding beats never exceed DEPTH
  always @(negedge clk_20) begin
    ncyc++;
    if (!rst_n) begin
      idx = 0; issued = 0; acc = 0; dones = 0; prev_eof = 1'b0;
    end else begin
      chk("frame_done", int'(frame_done), int'(prev_eof));
      if (frame_done) dones++;
      prev_eof = 1'b0;
      if (coord_valid) begin
        chk("credit", int'((issued - acc) < DEPTH), 1);
        chk("coord_x", int'(x), (issued % N) % H);
        chk("coord_y", int'(y), (issued % N) / H);
        issued++;
      end
      if (out_valid && out_ready) begin
        chk("data", int'(out_data), ((idx % N) / H) * 8 + (idx % N) % H);
        chk("sof", int'(out_sof), int'(idx % N == 0));
        chk("eol", int'(out_eol), int'((idx % N) % H == H - 1));
        prev_eof = (idx % N) == N - 1;
        if (idx < 24) t_hs[idx] = ncyc;
        idx++;
        acc++;
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; frame_req = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk_20);
    #1 rst_n = 1'b1;
  endtask

  task automatic drive(input int mode, input int n);
    out_ready = mode == 0 ? 1'b1 : mode == 1 ? ~out_ready :
                (mode == 3 && n < 30) ? 1'b0 : 1'($urandom % 2);
  endtask

  task automatic run_done(input int mode, input int target);
    int n = 0;
    while (dones < target && n < 3000) begin
      drive(mode, n);
      @(posedge clk_20); #1;
      n++;
    end
    chk("frames_done", dones, target);
  endtask

  task automatic wait_idle();
    int n = 0;
    out_ready = 1'b1;
    while (busy && n < 500) begin
      @(posedge clk_20); #1;
      n++;
    end
    chk("busy_falls", int'(busy), 0);
  endtask

  task automatic start_stalled();
    do_reset();
    frame_req = 1'b1;
    @(posedge clk_20); #1 frame_req = 1'b0;
    repeat (20) @(posedge clk_20);
    #1;
  endtask

  initial begin
    vt[0] = '{mode: 0, hold: 0, beats: 12, frames: 1};
    vt[1] = '{mode: 1, hold: 0, beats: 12, frames: 1};
    vt[2] = '{mode: 2, hold: 0, beats: 12, frames: 1};
    vt[3] = '{mode: 3, hold: 1, beats: 24, frames: 2};
    vt[4] = '{mode: 0, hold: 1, beats: 24, frames: 2};
    do_reset();
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_coord_valid", int'(coord_valid), 0);
    chk("rst_x", int'(x), 0);
    chk("rst_y", int'(y), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_out_data", int'(out_data), 0);
    for (int i = 0; i < 5; i++) begin
      do_reset();
      frame_req = 1'b1;
      drive(vt[i].mode, 0);
      @(posedge clk_20); #1;
      if (vt[i].hold == 0) frame_req = 1'b0;
      run_done(vt[i].mode, vt[i].frames);
      frame_req = 1'b0;
`ifndef STREAM_CONTINUOUS_EN
      wait_idle();
      chk("beats", acc, vt[i].beats);
      chk("end_out_valid", int'(out_valid), 0);
`endif
      if (i == 0) chk("throughput", t_hs[11] - t_hs[0], 11);
`ifdef STREAM_CONTINUOUS_EN
      if (i == 4) chk("frame_gap", t_hs[12] - t_hs[11], 1);
`else
      if (i == 4) chk("frame_gap", int'(t_hs[12] - t_hs[11] > 1), 1);
`endif
    end
    start_stalled();
    chk("stall_issued", issued, DEPTH);
    chk("stall_out_valid", int'(out_valid), 1);
    chk("stall_out_data", int'(out_data), 0);
    chk("stall_out_sof", int'(out_sof), 1);
    chk("stall_coord_valid", int'(coord_valid), 0);
    run_done(0, 1);
`ifndef STREAM_CONTINUOUS_EN
    wait_idle();
    chk("stall_beats", acc, N);
`endif
    start_stalled();
    chk("pre_rst_full", int'(out_valid), 1);
    rst_n = 1'b0;
    @(posedge clk_20); #1;
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_x", int'(x), 0);
    chk("mid_rst_y", int'(y), 0);
    rst_n = 1'b1;
    frame_req = 1'b1;
    @(posedge clk_20); #1 frame_req = 1'b0;
    run_done(0, 1);
`ifndef STREAM_CONTINUOUS_EN
    wait_idle();
    chk("post_rst_beats", acc, N);
`endif
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
